// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register: hold/shift/rotate/load/clear/invert with a word-length shift counter.
// Latency: 1 cycle from inputs to q; qbar/sl_out/sr_out are combinational from q.
// Backpressure: none; en=0 freezes all state and drops word_done.
module univ_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sl_in,
  input  logic             sr_in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sl_out,
  output logic             sr_out,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             word_done
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHL  = 3'b001,
    MODE_SHR  = 3'b010,
    MODE_ROL  = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_LOAD = 3'b101,
    MODE_CLR  = 3'b110,
    MODE_INV  = 3'b111
  } mode_e;

  // Counter saturates at the word length; the pulse fires on the edge that reaches it.
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mode_e            mode_sel;
  logic [WIDTH-1:0] q_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             done_nxt;
  logic             is_shift;

  assign mode_sel = mode_e'(mode);

  // Next-state decode for the register, the shift counter and the word_done pulse.
  always_comb begin
    q_nxt    = q;
    cnt_nxt  = shift_cnt;
    done_nxt = 1'b0;
    is_shift = 1'b0;
    if (en) begin
      case (mode_sel)
        MODE_SHL: begin
          q_nxt    = {q[WIDTH-2:0], sl_in};
          is_shift = 1'b1;
        end
        MODE_SHR: begin
          q_nxt    = {sr_in, q[WIDTH-1:1]};
          is_shift = 1'b1;
        end
        MODE_ROL: begin
          q_nxt    = {q[WIDTH-2:0], q[WIDTH-1]};
          is_shift = 1'b1;
        end
        MODE_ROR: begin
          q_nxt    = {q[0], q[WIDTH-1:1]};
          is_shift = 1'b1;
        end
        MODE_LOAD: begin
          q_nxt   = d;
          cnt_nxt = '0;
        end
        MODE_CLR: begin
          q_nxt   = '0;
          cnt_nxt = '0;
        end
        MODE_INV: q_nxt = ~q;
        default:  q_nxt = q;
      endcase
      // Only the WIDTH-1 -> WIDTH transition pulses; a saturated counter stays silent.
      if (is_shift && (shift_cnt < CNT_FULL)) begin
        cnt_nxt  = shift_cnt + CNT_ONE;
        done_nxt = (shift_cnt == (CNT_FULL - CNT_ONE));
      end
    end
  end

  // State registers; asynchronous reset discards any partially shifted word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q         <= RESET_VAL;
      shift_cnt <= '0;
      word_done <= 1'b0;
    end else begin
      q         <= q_nxt;
      shift_cnt <= cnt_nxt;
      word_done <= done_nxt;
    end
  end

  assign qbar   = ~q;
  assign sl_out = q[WIDTH-1];
  assign sr_out = q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] mode;
  logic [7:0] d;
  logic       sl_in;
  logic       sr_in;
  logic [7:0] q;
  logic [7:0] qbar;
  logic       sl_out;
  logic       sr_out;
  logic [3:0] shift_cnt;
  logic       word_done;

  int tests_run;
  int tests_failed;

  univ_shift_reg #(
    .WIDTH    (8),
    .RESET_VAL(8'hA5),
    .CNT_W    (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .d        (d),
    .sl_in    (sl_in),
    .sr_in    (sr_in),
    .q        (q),
    .qbar     (qbar),
    .sl_out   (sl_out),
    .sr_out   (sr_out),
    .shift_cnt(shift_cnt),
    .word_done(word_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    tests_run++;
    if (q !== 8'hA5) begin tests_failed++; $display("FAIL reset_q: got %h expected a5", q); end
    tests_run++;
    if (qbar !== 8'h5A) begin tests_failed++; $display("FAIL reset_qbar: got %h expected 5a", qbar); end
    tests_run++;
    if (shift_cnt !== 4'd0) begin tests_failed++; $display("FAIL reset_cnt: got %0d expected 0", shift_cnt); end
    tests_run++;
    if (word_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", word_done); end
    #2;
    rst  = 1'b1;
    en   = 1'b1;
    mode = 3'b000;
    step();
    step();
    tests_run++;
    if (q !== 8'hA5) begin tests_failed++; $display("FAIL hold_after_reset: got %h expected a5", q); end
    tests_run++;
    if (shift_cnt !== 4'd0) begin tests_failed++; $display("FAIL hold_cnt: got %0d expected 0", shift_cnt); end
  endtask

  task automatic test_load_shift_left();
    logic [7:0] exp_q [3];
    exp_q[0] = 8'h03;
    exp_q[1] = 8'h07;
    exp_q[2] = 8'h0F;
    en   = 1'b1;
    mode = 3'b101;
    d    = 8'h81;
    step();
    tests_run++;
    if (q !== 8'h81) begin tests_failed++; $display("FAIL load_q: got %h expected 81", q); end
    tests_run++;
    if (shift_cnt !== 4'd0) begin tests_failed++; $display("FAIL load_cnt: got %0d expected 0", shift_cnt); end
    tests_run++;
    if (sl_out !== 1'b1) begin tests_failed++; $display("FAIL sl_out_before_shift: got %b expected 1", sl_out); end
    tests_run++;
    if (sr_out !== 1'b1) begin tests_failed++; $display("FAIL sr_out_after_load: got %b expected 1", sr_out); end
    mode  = 3'b001;
    sl_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (q !== exp_q[i]) begin tests_failed++; $display("FAIL shl_q[%0d]: got %h expected %h", i, q, exp_q[i]); end
    end
    tests_run++;
    if (shift_cnt !== 4'd3) begin tests_failed++; $display("FAIL shl_cnt: got %0d expected 3", shift_cnt); end
    tests_run++;
    if (sl_out !== 1'b0) begin tests_failed++; $display("FAIL sl_out_after_shift: got %b expected 0", sl_out); end
  endtask

  task automatic test_deserialise();
    logic [7:0] bits;
    bits = 8'b0100_1101;  // bit i is the sr_in value of shift i
    en   = 1'b1;
    mode = 3'b110;
    step();
    tests_run++;
    if (q !== 8'h00 || shift_cnt !== 4'd0) begin
      tests_failed++; $display("FAIL clear: got q=%h cnt=%0d expected q=00 cnt=0", q, shift_cnt);
    end
    mode = 3'b010;
    for (int i = 0; i < 8; i++) begin
      sr_in = bits[i];
      step();
      tests_run++;
      if (shift_cnt !== 4'(i + 1)) begin tests_failed++; $display("FAIL deser_cnt[%0d]: got %0d expected %0d", i, shift_cnt, i + 1); end
      tests_run++;
      if (word_done !== (i == 7)) begin tests_failed++; $display("FAIL deser_done[%0d]: got %b expected %b", i, word_done, (i == 7)); end
    end
    tests_run++;
    if (q !== 8'h4D) begin tests_failed++; $display("FAIL deser_q: got %h expected 4d", q); end
    sr_in = 1'b1;
    step();
    tests_run++;
    if (q !== 8'hA6) begin tests_failed++; $display("FAIL ninth_shift_q: got %h expected a6", q); end
    tests_run++;
    if (shift_cnt !== 4'd8) begin tests_failed++; $display("FAIL sat_cnt: got %0d expected 8", shift_cnt); end
    tests_run++;
    if (word_done !== 1'b0) begin tests_failed++; $display("FAIL sat_no_pulse: got %b expected 0", word_done); end
  endtask

  task automatic test_rotate_invert();
    en   = 1'b1;
    mode = 3'b101;
    d    = 8'h01;
    step();
    mode = 3'b100;
    step();
    tests_run++;
    if (q !== 8'h80) begin tests_failed++; $display("FAIL ror_q: got %h expected 80", q); end
    mode = 3'b011;
    step();
    tests_run++;
    if (q !== 8'h01) begin tests_failed++; $display("FAIL rol1_q: got %h expected 01", q); end
    step();
    tests_run++;
    if (q !== 8'h02) begin tests_failed++; $display("FAIL rol2_q: got %h expected 02", q); end
    mode = 3'b111;
    step();
    tests_run++;
    if (q !== 8'hFD) begin tests_failed++; $display("FAIL inv_q: got %h expected fd", q); end
    tests_run++;
    if (qbar !== 8'h02) begin tests_failed++; $display("FAIL inv_qbar: got %h expected 02", qbar); end
    tests_run++;
    if (shift_cnt !== 4'd3) begin tests_failed++; $display("FAIL inv_cnt: got %0d expected 3", shift_cnt); end
  endtask

  task automatic test_enable_gating();
    en   = 1'b1;
    mode = 3'b101;
    d    = 8'h3C;
    step();
    mode = 3'b011;
    for (int i = 0; i < 8; i++) step();
    tests_run++;
    if (q !== 8'h3C || shift_cnt !== 4'd8 || word_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL rol8: got q=%h cnt=%0d done=%b expected q=3c cnt=8 done=1", q, shift_cnt, word_done);
    end
    en = 1'b0;
    d  = 8'hFF;
    for (int m = 1; m < 8; m++) begin
      mode = 3'(m);
      step();
      tests_run++;
      if (q !== 8'h3C) begin tests_failed++; $display("FAIL gate_q[mode %0d]: got %h expected 3c", m, q); end
      tests_run++;
      if (shift_cnt !== 4'd8) begin tests_failed++; $display("FAIL gate_cnt[mode %0d]: got %0d expected 8", m, shift_cnt); end
      tests_run++;
      if (word_done !== 1'b0) begin tests_failed++; $display("FAIL gate_done[mode %0d]: got %b expected 0", m, word_done); end
    end
  endtask

  task automatic test_reset_mid_word();
    int pulses;
    en   = 1'b1;
    mode = 3'b101;
    d    = 8'h3C;
    step();
    mode  = 3'b001;
    sl_in = 1'b0;
    for (int i = 0; i < 5; i++) step();
    tests_run++;
    if (shift_cnt !== 4'd5) begin tests_failed++; $display("FAIL mid_cnt: got %0d expected 5", shift_cnt); end
    #3;
    rst = 1'b0;
    #1;
    tests_run++;
    if (shift_cnt !== 4'd0) begin tests_failed++; $display("FAIL mid_reset_cnt: got %0d expected 0", shift_cnt); end
    tests_run++;
    if (q !== 8'hA5 || qbar !== 8'h5A) begin tests_failed++; $display("FAIL mid_reset_q: got q=%h qbar=%h expected a5/5a", q, qbar); end
    #2;
    rst   = 1'b1;
    mode  = 3'b010;
    sr_in = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (word_done === 1'b1) pulses++;
      tests_run++;
      if (word_done !== (i == 7)) begin tests_failed++; $display("FAIL rewind_done[%0d]: got %b expected %b", i, word_done, (i == 7)); end
    end
    tests_run++;
    if (pulses !== 1) begin tests_failed++; $display("FAIL rewind_pulses: got %0d expected 1", pulses); end
    tests_run++;
    if (q !== 8'hFF || shift_cnt !== 4'd8) begin tests_failed++; $display("FAIL rewind_end: got q=%h cnt=%0d expected ff/8", q, shift_cnt); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst   = 1'b1;
    en    = 1'b0;
    mode  = 3'b000;
    d     = 8'h00;
    sl_in = 1'b0;
    sr_in = 1'b0;
    test_reset();
    test_load_shift_left();
    test_deserialise();
    test_rotate_invert();
    test_enable_gating();
    test_reset_mid_word();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
